rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: port A (ALU result) and port B (memory load / external).
- Tracks a per-register pending scoreboard. The issue stage claims destinations; a completed write clears the claim.
- Gives the control sequencer a hazard flag so it stalls reads of registers still in flight.
- Sits between the execute/memory stages and the register file; drives its we/rd/wd write inputs from registers.

---
 rtl/rf_write_arbiter_if.sv | 54 +++++
 rtl/rf_write_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if
//   Groups the three request/response channels of the register-file
//   write arbiter: writeback port A, writeback port B and the issue-stage
//   claim port.
//
//   Handshake rule: a transfer happens on a rising clk edge where
//   valid && ready. While valid is high and ready is low, the requester
//   holds rd/wd stable. ready is a combinational function of the current
//   requests and the arbiter state. It never depends on a future cycle.
//
//   Signals:
//     a_valid/a_ready/a_rd/a_wd          port A (ALU result) writeback
//     b_valid/b_ready/b_rd/b_wd          port B (load / external) writeback
//     claim_valid/claim_ready/claim_rd   destination reservation
//
//   Modports:
//     master - requester side (execute/memory/issue stages, testbench)
//     slave  - arbiter side
interface rf_write_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_wd;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_wd;

    logic              claim_valid;
    logic              claim_ready;
    logic [ADDR_W-1:0] claim_rd;

    modport master (
        output a_valid, a_rd, a_wd,
        input  a_ready,
        output b_valid, b_rd, b_wd,
        input  b_ready,
        output claim_valid, claim_rd,
        input  claim_ready
    );

    modport slave (
        input  a_valid, a_rd, a_wd,
        output a_ready,
        input  b_valid, b_rd, b_wd,
        output b_ready,
        input  claim_valid, claim_rd,
        output claim_ready
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between two writeback
//   requesters (A = ALU, B = load/external) with round-robin arbitration.
//   It also keeps a per-register pending scoreboard. The issue stage sets a
//   bit when it claims a destination. The completed write clears that bit.
//
//   Ports:
//     clk, rst_n      clock (rising edge), asynchronous active-low reset
//     bus (slave)     A/B writeback and claim handshakes (see interface)
//     chk_rs, chk_rd  registers the sequencer wants to read / check
//     hazard          pending[chk_rs] | pending[chk_rd], combinational
//     pending         scoreboard, bit i = register i awaiting its write
//     rf_we/rf_rd/rf_wd  registered register-file write port, 1-cycle latency
//     err_unclaimed   sticky flag: a write landed on a non-pending register
//     dbg_rr_last     debug view of the arbiter state (0 = A, 1 = B)
module rf_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NREG   = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    rf_write_arbiter_if.slave   bus,
    input  logic [ADDR_W-1:0]   chk_rs,
    input  logic [ADDR_W-1:0]   chk_rd,
    output logic                hazard,
    output logic [NREG-1:0]     pending,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_rd,
    output logic [DATA_W-1:0]   rf_wd,
    output logic                err_unclaimed,
    output logic                dbg_rr_last
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Port that won the most recent grant. Reset to B so A wins first.
    port_e rr_last, rr_last_nxt;

    logic              grant_a;
    logic              grant_b;
    logic              wr_fire;
    logic [ADDR_W-1:0] wr_rd;
    logic [DATA_W-1:0] wr_wd;
    logic              claim_fire;
    logic [NREG-1:0]   pending_nxt;

    // Arbitration and next round-robin state. rst_n gates all readies, so
    // no handshake can be seen while the block is held in reset.
    always_comb begin
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        rr_last_nxt = rr_last;
        if (rst_n) begin
            if (bus.a_valid && bus.b_valid) begin
                grant_a = (rr_last == PORT_B);
                grant_b = (rr_last == PORT_A);
            end else begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid;
            end
        end
        if (grant_a) begin
            rr_last_nxt = PORT_A;
        end else if (grant_b) begin
            rr_last_nxt = PORT_B;
        end
    end

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;

    assign wr_fire = grant_a | grant_b;
    assign wr_rd   = grant_a ? bus.a_rd : bus.b_rd;
    assign wr_wd   = grant_a ? bus.a_wd : bus.b_wd;

    // A claim on a still-pending register stalls (WAW protection). The check
    // uses current pending, so a clear this cycle does not let a claim of
    // the same register through until the next cycle.
    assign bus.claim_ready = rst_n & bus.claim_valid & ~pending[bus.claim_rd];
    assign claim_fire      = bus.claim_ready;

    // Scoreboard update. The clear is applied before the set. A claim can
    // only coincide with a write to the same register when that write is
    // unclaimed. In that case the new reservation is kept.
    always_comb begin
        pending_nxt = pending;
        if (wr_fire) begin
            pending_nxt[wr_rd] = 1'b0;
        end
        if (claim_fire) begin
            pending_nxt[bus.claim_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last       <= PORT_B;
            pending       <= '0;
            rf_we         <= 1'b0;
            rf_rd         <= '0;
            rf_wd         <= '0;
            err_unclaimed <= 1'b0;
        end else begin
            rr_last <= rr_last_nxt;
            pending <= pending_nxt;
            rf_we   <= wr_fire;
            // Address/data hold their last values when there is no write.
            if (wr_fire) begin
                rf_rd <= wr_rd;
                rf_wd <= wr_wd;
                if (!pending[wr_rd]) begin
                    err_unclaimed <= 1'b1;
                end
            end
        end
    end

    assign hazard      = pending[chk_rs] | pending[chk_rd];
    assign dbg_rr_last = rr_last;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Directed bench for rf_write_arbiter. Inputs change 1 ns after a rising
//   edge. Combinational outputs are checked 1 ns later. Registered outputs
//   are checked 1 ns after the edge that updates them.
module tb_rf_write_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] chk_rs;
    logic [ADDR_W-1:0] chk_rd;
    logic              hazard;
    logic [NREG-1:0]   pending;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wd;
    logic              err_unclaimed;
    logic              dbg_rr_last;

    int vec_cnt;
    int err_cnt;

    rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .chk_rs        (chk_rs),
        .chk_rd        (chk_rd),
        .hazard        (hazard),
        .pending       (pending),
        .rf_we         (rf_we),
        .rf_rd         (rf_rd),
        .rf_wd         (rf_wd),
        .err_unclaimed (err_unclaimed),
        .dbg_rr_last   (dbg_rr_last)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check task
    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid     = 1'b0;
        bus.b_valid     = 1'b0;
        bus.claim_valid = 1'b0;
    endtask

    task automatic drive_a(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] wd);
        bus.a_valid = 1'b1;
        bus.a_rd    = rd;
        bus.a_wd    = wd;
    endtask

    task automatic drive_b(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] wd);
        bus.b_valid = 1'b1;
        bus.b_rd    = rd;
        bus.b_wd    = wd;
    endtask

    // Claim one register. The claim is accepted immediately
    // because the register is expected to be free.
    task automatic claim_one(input logic [ADDR_W-1:0] rd);
        bus.claim_valid = 1'b1;
        bus.claim_rd    = rd;
        tick();
        bus.claim_valid = 1'b0;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        chk_rs  = '0;
        chk_rd  = '0;
        bus.a_rd = '0; bus.a_wd = '0;
        bus.b_rd = '0; bus.b_wd = '0;
        bus.claim_rd = '0;

        // 1. Reset: readies held low even with every request raised.
        drive_a(3'd1, 8'h01);
        drive_b(3'd2, 8'h02);
        bus.claim_valid = 1'b1;
        bus.claim_rd    = 3'd0;
        tick();
        tick();
        check_val("rst_a_ready", bus.a_ready, 0);
        check_val("rst_b_ready", bus.b_ready, 0);
        check_val("rst_claim_ready", bus.claim_ready, 0);
        check_val("rst_rf_we", rf_we, 0);
        check_val("rst_pending", pending, 8'h00);
        check_val("rst_err", err_unclaimed, 0);
        idle_inputs();
        rst_n = 1'b1;
        tick();

        // 3. Contention after reset: A first, then B.
        claim_one(3'd2);
        claim_one(3'd5);
        check_val("t3_pending", pending, 8'h24);
        drive_a(3'd2, 8'h11);
        drive_b(3'd5, 8'h22);
        settle();
        check_val("t3_c1_a_ready", bus.a_ready, 1);
        check_val("t3_c1_b_ready", bus.b_ready, 0);
        tick();
        check_val("t3_c1_rf_we", rf_we, 1);
        check_val("t3_c1_rf_rd", rf_rd, 2);
        check_val("t3_c1_rf_wd", rf_wd, 8'h11);
        check_val("t3_c1_pending", pending, 8'h20);
        // A keeps a request up. Round robin must now favour B.
        settle();
        check_val("t3_c2_a_ready", bus.a_ready, 0);
        check_val("t3_c2_b_ready", bus.b_ready, 1);
        tick();
        idle_inputs();
        check_val("t3_c2_rf_we", rf_we, 1);
        check_val("t3_c2_rf_rd", rf_rd, 5);
        check_val("t3_c2_rf_wd", rf_wd, 8'h22);
        check_val("t3_c2_pending", pending, 8'h00);
        tick();
        check_val("t3_idle_rf_we", rf_we, 0);
        check_val("t3_idle_rf_rd_hold", rf_rd, 5);
        check_val("t3_idle_rf_wd_hold", rf_wd, 8'h22);

        // 2. Claim r3, then A writes r3 = 5A.
        bus.claim_valid = 1'b1;
        bus.claim_rd    = 3'd3;
        settle();
        check_val("t2_claim_ready", bus.claim_ready, 1);
        tick();
        bus.claim_valid = 1'b0;
        check_val("t2_pending", pending, 8'h08);
        drive_a(3'd3, 8'h5A);
        settle();
        check_val("t2_a_ready", bus.a_ready, 1);
        tick();
        idle_inputs();
        check_val("t2_rf_we", rf_we, 1);
        check_val("t2_rf_rd", rf_rd, 3);
        check_val("t2_rf_wd", rf_wd, 8'h5A);
        check_val("t2_pending", pending, 8'h00);
        check_val("t2_err", err_unclaimed, 0);

        // 4. Claim r4 while B clears r4 in the same cycle.
        claim_one(3'd4);
        check_val("t4_pending_set", pending, 8'h10);
        bus.claim_valid = 1'b1;
        bus.claim_rd    = 3'd4;
        drive_b(3'd4, 8'h44);
        settle();
        check_val("t4_claim_blocked", bus.claim_ready, 0);
        check_val("t4_b_ready", bus.b_ready, 1);
        tick();
        bus.b_valid = 1'b0;
        check_val("t4_pending_clr", pending, 8'h00);
        check_val("t4_rf_rd", rf_rd, 4);
        check_val("t4_rf_wd", rf_wd, 8'h44);
        settle();
        check_val("t4_claim_retry", bus.claim_ready, 1);
        tick();
        idle_inputs();
        check_val("t4_pending_reclaim", pending, 8'h10);
        check_val("t4_err", err_unclaimed, 0);
        drive_a(3'd4, 8'h4A);
        tick();
        idle_inputs();
        check_val("t4_pending_done", pending, 8'h00);

        // 5. Hazard and the unclaimed-write flag.
        claim_one(3'd1);
        check_val("t5_pending", pending, 8'h02);
        chk_rs = 3'd1;
        chk_rd = 3'd6;
        settle();
        check_val("t5_hazard_rs", hazard, 1);
        chk_rs = 3'd0;
        settle();
        check_val("t5_hazard_none", hazard, 0);
        chk_rd = 3'd1;
        settle();
        check_val("t5_hazard_rd", hazard, 1);
        drive_a(3'd6, 8'h66);
        tick();
        idle_inputs();
        check_val("t5_rf_rd", rf_rd, 6);
        check_val("t5_err_set", err_unclaimed, 1);
        check_val("t5_pending_kept", pending, 8'h02);
        tick();
        tick();
        check_val("t5_err_sticky", err_unclaimed, 1);

        // 6. Asynchronous reset with a write in flight and pending = FF.
        for (int i = 0; i < NREG; i++) begin
            if (i != 1) claim_one(ADDR_W'(i));
        end
        check_val("t6_pending_full", pending, 8'hFF);
        drive_a(3'd0, 8'hA0);
        tick();
        check_val("t6_rf_we_pre", rf_we, 1);
        drive_a(3'd2, 8'hA2);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rf_we", rf_we, 0);
        check_val("t6_rf_rd", rf_rd, 0);
        check_val("t6_rf_wd", rf_wd, 0);
        check_val("t6_pending", pending, 8'h00);
        check_val("t6_err", err_unclaimed, 0);
        check_val("t6_a_ready", bus.a_ready, 0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        drive_a(3'd3, 8'h33);
        drive_b(3'd7, 8'h77);
        settle();
        check_val("t6_post_a_ready", bus.a_ready, 1);
        check_val("t6_post_b_ready", bus.b_ready, 0);
        tick();
        idle_inputs();
        check_val("t6_post_rf_rd", rf_rd, 3);
        check_val("t6_post_rf_wd", rf_wd, 8'h33);
        tick();

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
